// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - output stream bundle of the FIFO stream reader
//
// Purpose: groups the valid/ready word stream leaving fifo_stream_reader.
// Parameters:
//   DWIDTH  stream data width
// Signals:
//   m_valid  word present on m_data
//   m_data   stream word
//   m_last   final word of the burst, qualified by m_valid
//   m_ready  downstream accepts the word this cycle
// Modports:
//   master  driven by the reader (valid/data/last out, ready in)
//   slave   downstream consumer

interface fifo_stream_reader_if #(
  parameter int DWIDTH = 16
);
  logic              m_valid;
  logic [DWIDTH-1:0] m_data;
  logic              m_last;
  logic              m_ready;

  modport master (
    output m_valid,
    output m_data,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_valid,
    input  m_data,
    input  m_last,
    output m_ready
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - burst read controller from a synchronous FIFO onto a valid/ready stream
//
// Purpose: on a start pulse pops exactly len words from a FIFO with
// registered read data and forwards them on a valid/ready stream, marking the
// final word with m_last. A 3-entry buffer covers the one-cycle read latency
// plus backpressure, so the block runs at one word per cycle and fifo_rd_en
// never depends combinationally on m_ready.
// Optional feature macro: FIFO_RD_TIMEOUT_EN adds an empty-stall abort and
// the timeout output.
// Ports:
//   clk         clock, posedge
//   rstn        synchronous active-low reset
//   start       burst request, sampled only while idle
//   len         burst length in words, sampled with start
//   busy        high whenever a burst is in progress
//   done        one-cycle pulse at burst completion
//   fifo_empty  FIFO empty flag
//   fifo_dout   FIFO read data, valid the cycle after a pop
//   fifo_rd_en  FIFO pop request
//   timeout     (FIFO_RD_TIMEOUT_EN only) one-cycle pulse on stall abort
//   m           output stream (fifo_stream_reader_if.master)

module fifo_stream_reader #(
  parameter int DWIDTH         = 16,
  parameter int LWIDTH         = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [LWIDTH-1:0] len,
  output logic              busy,
  output logic              done,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_dout,
  output logic              fifo_rd_en,
`ifdef FIFO_RD_TIMEOUT_EN
  output logic              timeout,
`endif
  fifo_stream_reader_if.master m
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 16-bit stall counter");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state;
  logic [DWIDTH-1:0] mem [3];
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [1:0]        count;
  logic              inflight;
  logic [LWIDTH-1:0] issue_rem;
  logic [LWIDTH-1:0] out_rem;

  logic              m_valid_i;
  logic              m_last_i;
  logic              hs;
  logic [2:0]        occupancy;

  // Words already committed to the buffer: stored ones plus the one whose
  // data arrives at the next edge. Capping this at 3 is what lets the block
  // keep issuing without ever looking at m_ready.
  assign occupancy  = {1'b0, count} + {2'b00, inflight};

  assign fifo_rd_en = (state == S_READ) && !fifo_empty &&
                      (issue_rem != '0) && (occupancy < 3'd3);

  assign m_valid_i  = (count != 2'd0);
  assign m_last_i   = m_valid_i && (out_rem == LWIDTH'(1));
  assign hs         = m_valid_i && m.m_ready;

  assign m.m_valid  = m_valid_i;
  assign m.m_data   = mem[rd_ptr];
  assign m.m_last   = m_last_i;

  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

`ifdef FIFO_RD_TIMEOUT_EN
  logic [15:0]       stall_cnt;
  logic              stall_hit;
  logic [LWIDTH-1:0] undelivered;

  assign stall_hit   = (state == S_READ) && fifo_empty &&
                       (stall_cnt == 16'(TIMEOUT_CYCLES - 1));
  // Words still owed downstream after this edge; a handshake in the abort
  // cycle itself is already accounted for.
  assign undelivered = LWIDTH'(occupancy) - LWIDTH'(hs);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      stall_cnt <= '0;
      timeout   <= 1'b0;
    end else begin
      timeout <= stall_hit;
      if (state != S_READ || fifo_rd_en || stall_hit) begin
        stall_cnt <= '0;
      end else if (fifo_empty) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      count     <= 2'd0;
      inflight  <= 1'b0;
      issue_rem <= '0;
      out_rem   <= '0;
      for (int i = 0; i < 3; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // fifo_dout only carries a real word the cycle after a pop.
      if (inflight) begin
        mem[wr_ptr] <= fifo_dout;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (hs) begin
        rd_ptr  <= ptr_inc(rd_ptr);
        out_rem <= out_rem - LWIDTH'(1);
      end
      count    <= count + {1'b0, inflight} - {1'b0, hs};
      inflight <= fifo_rd_en;
      if (fifo_rd_en) begin
        issue_rem <= issue_rem - LWIDTH'(1);
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            issue_rem <= len;
            out_rem   <= len;
            state     <= (len == '0) ? S_DONE : S_READ;
          end
        end
        S_READ: begin
          if (fifo_rd_en && issue_rem == LWIDTH'(1)) begin
            state <= S_DRAIN;
          end
`ifdef FIFO_RD_TIMEOUT_EN
          if (stall_hit) begin
            issue_rem <= '0;
            out_rem   <= undelivered;
            state     <= (undelivered == '0) ? S_DONE : S_DRAIN;
          end
`endif
        end
        S_DRAIN: begin
          if (hs && m_last_i) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
